// File: rtl/cpu_debug_pkg.sv
// cpu_debug_pkg: shared definitions for the 6502 debug controller.
//   - controller state encoding
//   - register-window offsets
//   - control/status bit positions in the offset-0 register
package cpu_debug_pkg;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_STOP       = 3'd1,
    ST_STEP_ARMED = 3'd2,
    ST_STEP_WAIT  = 3'd3,
    ST_RESET_WAIT = 3'd4
  } dbg_state_t;

  // Register offsets relative to the window base.
  localparam logic [7:0] OFF_CTRL     = 8'd0;
  localparam logic [7:0] OFF_STEP_CNT = 8'd1;
  localparam logic [7:0] OFF_BP_HIT   = 8'd2;
  localparam logic [7:0] OFF_BP_EN    = 8'd3;
  localparam logic [7:0] OFF_BP_BASE  = 8'd4;  // bp i lo at 4+2i, hi at 5+2i

  // Offset-0 write bits.
  localparam int CTRL_ARM_BIT = 5;
  localparam int CTRL_CLR_BIT = 4;

  // Offset of breakpoint i's low address byte.
  function automatic logic [7:0] bp_lo_off(input int i);
    return 8'(int'(OFF_BP_BASE) + 2 * i);
  endfunction

endpackage

// File: rtl/bp_comparator.sv
// bp_comparator: one opcode-fetch breakpoint.
//   clk, rst_n   : clock, synchronous active-low reset
//   wr_lo, wr_hi : load low / high address byte from wdata
//   wdata        : monitor write data
//   en           : comparator enable (one BP_EN bit)
//   rise         : SYNC rising edge this cycle
//   cpu_addr     : CPU address bus
//   addr         : stored breakpoint address (for read-back)
//   match        : rise & en & address equal, same cycle as rise
module bp_comparator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [7:0]  wdata,
  input  logic        en,
  input  logic        rise,
  input  logic [15:0] cpu_addr,
  output logic [15:0] addr,
  output logic        match
);

  logic [15:0] addr_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg <= '0;
    end else begin
      if (wr_lo) addr_reg[7:0]  <= wdata;
      if (wr_hi) addr_reg[15:8] <= wdata;
    end
  end

  assign addr  = addr_reg;
  assign match = rise & en & (cpu_addr == addr_reg);

endmodule

// File: rtl/edge_detect.sv
// edge_detect: rising-edge detector.
//   clk, rst_n : clock, synchronous active-low reset
//   sig        : input level (already synchronous to clk)
//   rise       : combinational, high while sig=1 and its last sampled value was 0
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_reg <= 1'b0;
    end else begin
      sig_reg <= sig;
    end
  end

  assign rise = sig & ~sig_reg;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl: halt / run / N-step / breakpoint controller for a 6502,
// driven from a memory-mapped register window and front-panel buttons.
// Entry to STOP fires a one-cycle nmi_req into the external NMI stretcher.
//   clk, rst_n          : clock, synchronous active-low reset
//   A, write, Din       : monitor bus; writes qualified by win_hit
//   Dout                : registered read data, valid the cycle after A
//   win_hit             : combinational, A inside the register window
//   cpu_addr, sync      : CPU address bus and SYNC (opcode fetch)
//   b_runhalt, b_step, b_reset : single-cycle button pulses
//   nmi_req             : one-cycle pulse on every entry to STOP
//   stopped             : controller is in STOP
//   bp_hit              : sticky per-breakpoint hit flags
module cpu_debug_ctrl
  import cpu_debug_pkg::*;
#(
  parameter logic [7:0] BASE          = 8'hE0,
  parameter int         NUM_BP        = 2,
  parameter int         STEP_OVERHEAD = 2,
  parameter int         RESET_SYNCS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        A,
  input  logic              write,
  input  logic [7:0]        Din,
  output logic [7:0]        Dout,
  output logic              win_hit,
  input  logic [15:0]       cpu_addr,
  input  logic              sync,
  input  logic              b_runhalt,
  input  logic              b_step,
  input  logic              b_reset,
  output logic              nmi_req,
  output logic              stopped,
  output logic [NUM_BP-1:0] bp_hit
);

  localparam logic [7:0] LAST_OFF = 8'(3 + 2 * NUM_BP);

  dbg_state_t        state_reg, state_next;
  logic [8:0]        cnt_reg, cnt_next;
  logic [7:0]        step_cnt_reg;
  logic [NUM_BP-1:0] bp_en_reg;
  logic [NUM_BP-1:0] bp_hit_reg, bp_hit_next, hit_set;
  logic [7:0]        dout_reg, rd_data;
  logic              nmi_reg;

  logic [7:0]        off;
  logic              wr, wr_ctrl, arm, clr_all;
  logic              rise;
  logic [NUM_BP-1:0] match;
  logic [15:0]       bp_addr [NUM_BP];
  logic [7:0]        hit8, en8;
  logic [9:0]        step_target;

  // ---------------------------------------------------------------- window
  // A below BASE wraps to a large offset, so the A >= BASE term is needed.
  assign off     = A - BASE;
  assign win_hit = (A >= BASE) && (off <= LAST_OFF);
  assign wr      = write & win_hit;
  assign wr_ctrl = wr && (off == OFF_CTRL);
  assign arm     = wr_ctrl & Din[CTRL_ARM_BIT];
  assign clr_all = wr_ctrl & Din[CTRL_CLR_BIT];

  // ------------------------------------------------------------- SYNC edge
  edge_detect u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (sync),
    .rise  (rise)
  );

  // ----------------------------------------------------------- breakpoints
  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
    bp_comparator u_bp (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_lo    (wr && (off == bp_lo_off(gi))),
      .wr_hi    (wr && (off == bp_lo_off(gi) + 8'd1)),
      .wdata    (Din),
      .en       (bp_en_reg[gi]),
      .rise     (rise),
      .cpu_addr (cpu_addr),
      .addr     (bp_addr[gi]),
      .match    (match[gi])
    );
  end

  // 8-bit views of the per-breakpoint registers; unused bits read 0.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pad
    if (gi < NUM_BP) begin : g_used
      assign hit8[gi] = bp_hit_reg[gi];
      assign en8[gi]  = bp_en_reg[gi];
    end else begin : g_zero
      assign hit8[gi] = 1'b0;
      assign en8[gi]  = 1'b0;
    end
  end

  // ---------------------------------------------------------------- FSM
  // Sync edge on which the step run ends: the overhead edges of the monitor
  // exit, then max(step_cnt,1) user instructions. Counter starts at 0.
  assign step_target = 10'(STEP_OVERHEAD) - 10'd1 +
                       ((step_cnt_reg == 8'd0) ? 10'd1 : {2'b00, step_cnt_reg});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
      nmi_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      nmi_reg   <= (state_next == ST_STOP) && (state_reg != ST_STOP);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hit_set    = '0;
    unique case (state_reg)
      ST_RUN: begin
        if (b_runhalt | b_step) state_next = ST_STOP;
        if (|match) begin
          state_next = ST_STOP;
          hit_set    = match;
        end
      end
      ST_STOP: begin
        if (b_reset) begin
          state_next = ST_RESET_WAIT;
          cnt_next   = '0;
        end else if (b_runhalt) begin
          state_next = ST_RUN;
        end else if (b_step) begin
          state_next = ST_STEP_ARMED;
        end
      end
      ST_STEP_ARMED: begin
        if (b_reset) begin
          state_next = ST_RUN;
        end else if (arm) begin
          state_next = ST_STEP_WAIT;
          cnt_next   = '0;
        end
      end
      ST_STEP_WAIT: begin
        if (b_reset) begin
          state_next = ST_RUN;
        end else if (rise) begin
          cnt_next = cnt_reg + 9'd1;
          if ({1'b0, cnt_reg} == step_target) state_next = ST_STOP;
          // Fetches inside the monitor exit path must not trip breakpoints.
          if ((|match) && (cnt_reg >= 9'(STEP_OVERHEAD))) begin
            state_next = ST_STOP;
            hit_set    = match;
          end
        end
      end
      ST_RESET_WAIT: begin
        if (b_reset) begin
          state_next = ST_RUN;
        end else if (rise) begin
          cnt_next = cnt_reg + 9'd1;
          if (cnt_reg == 9'(RESET_SYNCS - 1)) state_next = ST_STOP;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // ------------------------------------------------------------ registers
  // A hit flagged this cycle survives a simultaneous clear.
  always_comb begin
    bp_hit_next = bp_hit_reg;
    if (clr_all) bp_hit_next = '0;
    if (wr && (off == OFF_BP_HIT)) bp_hit_next = bp_hit_next & ~Din[NUM_BP-1:0];
    bp_hit_next = bp_hit_next | hit_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt_reg <= '0;
      bp_en_reg    <= '0;
      bp_hit_reg   <= '0;
    end else begin
      if (wr && (off == OFF_STEP_CNT)) step_cnt_reg <= Din;
      if (wr && (off == OFF_BP_EN))    bp_en_reg    <= Din[NUM_BP-1:0];
      bp_hit_reg <= bp_hit_next;
    end
  end

  // ------------------------------------------------------------ read path
  always_comb begin
    rd_data = '0;
    case (off)
      OFF_CTRL:     rd_data = {stopped, state_reg == ST_STEP_WAIT, |bp_hit_reg, 5'b0};
      OFF_STEP_CNT: rd_data = step_cnt_reg;
      OFF_BP_HIT:   rd_data = hit8;
      OFF_BP_EN:    rd_data = en8;
      default: begin
        for (int i = 0; i < NUM_BP; i++) begin
          if (off == bp_lo_off(i))        rd_data = bp_addr[i][7:0];
          if (off == bp_lo_off(i) + 8'd1) rd_data = bp_addr[i][15:8];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_reg <= '0;
    end else if (win_hit) begin
      dout_reg <= rd_data;
    end
  end

  assign Dout    = dout_reg;
  assign nmi_req = nmi_reg;
  assign stopped = (state_reg == ST_STOP);
  assign bp_hit  = bp_hit_reg;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// tb_cpu_debug_ctrl: directed scenarios plus randomized traffic, all
// checked each cycle against a behavioural model of the controller.
module tb_cpu_debug_ctrl;

  localparam logic [7:0] BASE          = 8'hE0;
  localparam int         NUM_BP        = 2;
  localparam int         STEP_OVERHEAD = 2;
  localparam int         RESET_SYNCS   = 1;
  localparam int         LAST          = 3 + 2 * NUM_BP;
  localparam logic [7:0] MASK          = 8'((1 << NUM_BP) - 1);

  localparam logic [2:0] M_RUN = 3'd0, M_STOP = 3'd1, M_ARMED = 3'd2,
                         M_SW  = 3'd3, M_RW   = 3'd4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        A = 8'h00;
  logic              write = 1'b0;
  logic [7:0]        Din = 8'h00;
  logic [7:0]        Dout;
  logic              win_hit;
  logic [15:0]       cpu_addr = 16'h0000;
  logic              sync = 1'b0;
  logic              b_runhalt = 1'b0, b_step = 1'b0, b_reset = 1'b0;
  logic              nmi_req;
  logic              stopped;
  logic [NUM_BP-1:0] bp_hit;

  int total = 0;
  int bad = 0;
  int nmi_cnt = 0;
  logic chk_on = 1'b0;

  cpu_debug_ctrl #(
    .BASE(BASE), .NUM_BP(NUM_BP), .STEP_OVERHEAD(STEP_OVERHEAD), .RESET_SYNCS(RESET_SYNCS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .write(write), .Din(Din), .Dout(Dout),
    .win_hit(win_hit), .cpu_addr(cpu_addr), .sync(sync), .b_runhalt(b_runhalt),
    .b_step(b_step), .b_reset(b_reset), .nmi_req(nmi_req), .stopped(stopped),
    .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------- model
  typedef struct packed {
    logic [2:0]              mode;
    logic [7:0]              dout;
    logic                    nmi;
    logic [7:0]              sc;
    logic [7:0]              en;
    logic [7:0]              hit;
    logic [NUM_BP-1:0][15:0] bpa;
    logic [9:0]              edges;
    logic                    sync_q;
  } mstate_t;

  mstate_t m;

  function automatic logic in_window(input logic [7:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) - int'(BASE) <= LAST);
  endfunction

  function automatic logic [7:0] read_val(input mstate_t s, input int off);
    if (off == 0) return {s.mode == M_STOP, s.mode == M_SW, s.hit != 8'h00, 5'b0};
    if (off == 1) return s.sc;
    if (off == 2) return s.hit;
    if (off == 3) return s.en;
    if (off % 2 == 0) return s.bpa[(off - 4) / 2][7:0];
    return s.bpa[(off - 4) / 2][15:8];
  endfunction

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n;
    logic rise, inwin, wr;
    int off, need;
    logic [7:0] mt, hs;
    n = s;
    if (!rst_n) begin
      n = '0;
      n.mode = M_RUN;
      return n;
    end
    rise  = sync && !s.sync_q;
    inwin = in_window(A);
    off   = int'(A) - int'(BASE);
    wr    = write && inwin;
    if (inwin) n.dout = read_val(s, off);
    mt = '0;
    for (int i = 0; i < NUM_BP; i++)
      if (rise && s.en[i] && cpu_addr == s.bpa[i]) mt[i] = 1'b1;
    // Total sync rises the step run lasts, counting the monitor exit.
    need = STEP_OVERHEAD + ((s.sc == 8'd0) ? 1 : int'(s.sc));
    hs = '0;
    case (s.mode)
      M_RUN: begin
        if (b_runhalt || b_step || mt != 0) n.mode = M_STOP;
        hs = mt;
      end
      M_STOP: begin
        if (b_reset) begin n.mode = M_RW; n.edges = 0; end
        else if (b_runhalt) n.mode = M_RUN;
        else if (b_step) n.mode = M_ARMED;
      end
      M_ARMED: begin
        if (b_reset) n.mode = M_RUN;
        else if (wr && off == 0 && Din[5]) begin n.mode = M_SW; n.edges = 0; end
      end
      M_SW: begin
        if (b_reset) n.mode = M_RUN;
        else if (rise) begin
          n.edges = s.edges + 1;
          if (int'(n.edges) == need) n.mode = M_STOP;
          if (mt != 0 && int'(s.edges) >= STEP_OVERHEAD) begin
            n.mode = M_STOP;
            hs = mt;
          end
        end
      end
      M_RW: begin
        if (b_reset) n.mode = M_RUN;
        else if (rise) begin
          n.edges = s.edges + 1;
          if (int'(n.edges) == RESET_SYNCS) n.mode = M_STOP;
        end
      end
      default: n.mode = M_RUN;
    endcase
    if (wr) begin
      if (off == 1) n.sc = Din;
      if (off == 3) n.en = Din & MASK;
      for (int i = 0; i < NUM_BP; i++) begin
        if (off == 4 + 2 * i) n.bpa[i][7:0]  = Din;
        if (off == 5 + 2 * i) n.bpa[i][15:8] = Din;
      end
    end
    n.hit = s.hit;
    if (wr && off == 0 && Din[4]) n.hit = 8'h00;
    if (wr && off == 2) n.hit = n.hit & ~Din;
    n.hit = (n.hit | hs) & MASK;
    n.nmi = (n.mode == M_STOP) && (s.mode != M_STOP);
    n.sync_q = sync;
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m);

  // ---------------------------------------------------------- checking
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp,
                     input bit verbose);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end else if (verbose) begin
      $display("check %s: %h", nm, act);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("dout", 16'(Dout), 16'(m.dout), 1'b0);
      chk("nmi_req", 16'(nmi_req), 16'(m.nmi), 1'b0);
      chk("stopped", 16'(stopped), 16'(m.mode == M_STOP), 1'b0);
      chk("bp_hit", 16'(bp_hit), 16'(m.hit[NUM_BP-1:0]), 1'b0);
      chk("win_hit", 16'(win_hit), 16'(in_window(A)), 1'b0);
    end
  end

  always @(negedge clk) if (chk_on && nmi_req === 1'b1) nmi_cnt <= nmi_cnt + 1;

  // ---------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_reg(input int off, input logic [7:0] d);
    A = BASE + 8'(off); write = 1'b1; Din = d;
    tick();
    write = 1'b0; A = 8'h00;
  endtask

  task automatic rd_reg(input int off, output logic [7:0] d);
    A = BASE + 8'(off);
    tick();
    d = Dout;
    A = 8'h00;
  endtask

  task automatic press(input int which);
    if (which == 0) b_runhalt = 1'b1;
    if (which == 1) b_step = 1'b1;
    if (which == 2) b_reset = 1'b1;
    tick();
    b_runhalt = 1'b0; b_step = 1'b0; b_reset = 1'b0;
  endtask

  // Produces up to max sync rises; returns the 1-based rise on which
  // nmi_req appeared, or 0 if none. Rise number match_at carries C123.
  task automatic run_rises(input int max, input int match_at, output int at);
    at = 0;
    for (int k = 1; k <= max; k++) begin
      cpu_addr = (k == match_at) ? 16'hC123 : 16'h1000;
      sync = 1'b1;
      tick();
      sync = 1'b0;
      if (nmi_req === 1'b1 && at == 0) at = k;
      tick();
      if (at != 0) break;
    end
  endtask

  logic [7:0] d;
  int at, n0;

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Reset state.
    rd_reg(0, d);
    chk("reset_off0", 16'(d), 16'h00, 1'b1);
    chk("reset_stopped", 16'(stopped), 16'h0, 1'b1);
    A = BASE + 8'(LAST); #1;
    chk("win_last", 16'(win_hit), 16'h1, 1'b1);
    A = BASE + 8'(LAST + 1); #1;
    chk("win_past", 16'(win_hit), 16'h0, 1'b1);
    A = BASE - 8'd1; #1;
    chk("win_below", 16'(win_hit), 16'h0, 1'b1);
    A = 8'h00;
    chk("reset_nmi_cnt", 16'(nmi_cnt), 16'd0, 1'b1);

    // Halt from RUN.
    press(0);
    chk("halt_nmi_hi", 16'(nmi_req), 16'h1, 1'b1);
    tick();
    chk("halt_nmi_lo", 16'(nmi_req), 16'h0, 1'b1);
    chk("halt_stopped", 16'(stopped), 16'h1, 1'b1);
    rd_reg(0, d);
    chk("halt_off0", 16'(d), 16'h80, 1'b1);

    // Single step with STEP_CNT=0.
    press(1);
    wr_reg(0, 8'h20);
    rd_reg(0, d);
    chk("stepwait_off0", 16'(d), 16'h40, 1'b1);
    run_rises(12, 0, at);
    chk("step0_rise", 16'(at), 16'd3, 1'b1);

    // STEP_CNT=4.
    wr_reg(1, 8'h04);
    press(1);
    wr_reg(0, 8'h20);
    run_rises(12, 0, at);
    chk("step4_rise", 16'(at), 16'd6, 1'b1);

    // Breakpoint setup and BP_EN width.
    wr_reg(3, 8'hFF);
    rd_reg(3, d);
    chk("bp_en_mask", 16'(d), 16'h03, 1'b1);
    wr_reg(3, 8'h02);
    wr_reg(6, 8'h23);
    wr_reg(7, 8'hC1);
    rd_reg(7, d);
    chk("bp1_hi", 16'(d), 16'hC1, 1'b1);
    n0 = nmi_cnt;
    press(0);
    tick();
    chk("resume_no_nmi", 16'(nmi_cnt - n0), 16'd0, 1'b1);
    run_rises(6, 2, at);
    chk("bp_run_rise", 16'(at), 16'd2, 1'b1);
    rd_reg(2, d);
    chk("bp_hit_reg", 16'(d), 16'h02, 1'b1);
    rd_reg(0, d);
    chk("bp_off0", 16'(d), 16'hA0, 1'b1);
    wr_reg(2, 8'h02);
    rd_reg(2, d);
    chk("bp_w1c", 16'(d), 16'h00, 1'b1);

    // Breakpoint inside a step run, then during overhead.
    wr_reg(1, 8'h05);
    press(1);
    wr_reg(0, 8'h20);
    run_rises(12, 4, at);
    chk("step_bp_rise", 16'(at), 16'd4, 1'b1);
    rd_reg(2, d);
    chk("step_bp_hit", 16'(d), 16'h02, 1'b1);
    wr_reg(0, 8'h10);
    rd_reg(2, d);
    chk("clr_all", 16'(d), 16'h00, 1'b1);
    press(1);
    wr_reg(0, 8'h20);
    run_rises(12, 1, at);
    chk("overhead_bp_ignored", 16'(at), 16'd7, 1'b1);

    // Reset in the middle of a step run.
    press(1);
    wr_reg(0, 8'h20);
    run_rises(2, 0, at);
    n0 = nmi_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_stopped", 16'(stopped), 16'h0, 1'b1);
    for (int o = 0; o <= LAST; o++) begin
      rd_reg(o, d);
      chk($sformatf("midrst_off%0d", o), 16'(d), 16'h00, 1'b1);
    end
    run_rises(6, 1, at);
    chk("midrst_no_nmi", 16'(nmi_cnt - n0), 16'd0, 1'b1);

    // Randomized traffic.
    wr_reg(4, 8'hAB);
    wr_reg(3, 8'h03);
    for (int c = 0; c < 4000; c++) begin
      int sel;
      rst_n     = ($urandom_range(0, 599) != 0);
      b_runhalt = ($urandom_range(0, 59) == 0);
      b_step    = ($urandom_range(0, 59) == 0);
      b_reset   = ($urandom_range(0, 89) == 0);
      sync      = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      cpu_addr  = (sel == 0) ? 16'hC123 : (sel == 1) ? 16'h00AB :
                  (sel == 2) ? 16'h0000 : 16'($urandom);
      A = ($urandom_range(0, 7) != 0) ? BASE + 8'($urandom_range(0, LAST + 2))
                                      : 8'($urandom);
      write = ($urandom_range(0, 5) == 0);
      Din = 8'($urandom);
      if (A == BASE + 8'd1) Din = Din & 8'h07;
      if (write)
        $display("txn %0d: write A=%h Din=%h btn=%b%b%b sync=%b", c, A, Din,
                 b_reset, b_runhalt, b_step, sync);
      tick();
    end
    rst_n = 1'b1; write = 1'b0; sync = 1'b0;
    b_runhalt = 1'b0; b_step = 1'b0; b_reset = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_debug_ctrl.md
Name: cpu_debug_ctrl

Overview:
Parametrised successor to the front-panel CPU controller. It halts, runs and steps the 6502 by firing NMI into the monitor, and adds N-instruction stepping and NUM_BP opcode-fetch breakpoints. The monitor reaches all of this through a memory-mapped register window at BASE. Monitor ROM and the interrupt pulse stretcher stay outside the block; this block outputs a one-cycle nmi_req.

Parameters:
BASE, 8'hE0, first address of register window (A[7:0] space)
NUM_BP, 2, breakpoint comparators, legal 1..8
STEP_OVERHEAD, 2, sync rising edges consumed by monitor exit (RTI path) before a user instruction counts
RESET_SYNCS, 1, sync rising edges after reset request before NMI

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
A  in  8  monitor address bus
write  in  1  monitor write strobe, qualified by A
Din  in  8  monitor write data
Dout  out  8  registered read data; valid cycle after A
win_hit  out  1  combinational: A inside window; top muxes Dout vs ROM
cpu_addr  in  16  CPU address bus
sync  in  1  CPU SYNC (opcode fetch)
b_runhalt, b_step, b_reset  in  1 each  single-cycle debounced button pulses
nmi_req  out  1  one-cycle request to NMI stretcher
stopped  out  1  state == STOP
bp_hit  out  NUM_BP  sticky breakpoint-hit flags

Behaviour:
- Reset (rst_n low at clk edge): state RUN, Dout 0, nmi_req 0, step_cnt 0, bp_en 0, bp_hit 0, all bp_addr 0, edge counter 0.
- Window: offsets 0..3+2*NUM_BP from BASE; win_hit is 1 only there. Dout updates every cycle win_hit=1; otherwise holds.
- Map:
  - off0: read {stopped, state==STEP_WAIT, |bp_hit, 5'b0}; write bit5 = arm step, bit4 = clear all bp_hit.
  - off1: STEP_CNT, R/W; 0 behaves as 1.
  - off2: BP_HIT, read; write-1-to-clear per bit.
  - off3: BP_EN, R/W.
  - off 4+2i / 5+2i: bp_addr[i] lo/hi, R/W.
  - Bits above NUM_BP read 0 and ignore writes.
- Sync edge: registered sync; rise = sync & ~sync_q. Breakpoint match = rise & bp_en[i] & (cpu_addr == bp_addr[i]), sampled in the same cycle as rise.
- Edge counter: 9 bits, counts rises in STEP_WAIT and RESET_WAIT.
- FSM, button priority b_reset > b_runhalt > b_step. nmi_req pulses for exactly one cycle on every entry to STOP.
  - RUN: b_runhalt|b_step -> STOP. Any match -> STOP and set the matching bp_hit bits.
  - STOP: b_reset -> RESET_WAIT (cnt=0). b_runhalt -> RUN. b_step -> STEP_ARMED. No NMI on exit.
  - STEP_ARMED: b_reset -> RUN. Arm write -> STEP_WAIT (cnt=0).
  - STEP_WAIT: b_reset -> RUN. On rise, cnt++. Stop on the rise where cnt == STEP_OVERHEAD+max(step_cnt,1)-1. A match on a rise where cnt >= STEP_OVERHEAD also stops early and sets bp_hit. A match during overhead edges is ignored.
  - RESET_WAIT: b_reset -> RUN. Stop on the rise where cnt == RESET_SYNCS-1.
- Arm write outside STEP_ARMED is ignored; it is not remembered.
- A register write and an FSM event in the same cycle both take effect. A bp_hit set and a W1C clear in the same cycle on the same bit: set wins.
- Mid-operation reset abandons any count; no nmi_req is produced.

Decomposition:
- cpu_debug_pkg: state encodings (RUN=0, STOP=1, STEP_ARMED=2, STEP_WAIT=3, RESET_WAIT=4), register offsets, control bit positions.
- Sub-module bp_comparator (one per NUM_BP via generate): holds addr, output match.
- Existing edge_detect is reused for sync.

Test Plan:
- Reset, then read BASE+0 -> Dout 8'h00 one cycle later; stopped 0; nmi_req never pulses.
- b_runhalt in RUN -> nmi_req high exactly 1 cycle, stopped 1; read off0 = 8'h80.
- STOP, b_step, write 8'h20 to off0 with STEP_CNT=0 -> nmi_req on 3rd sync rise. STEP_CNT=4 -> nmi_req on 6th rise.
- BP_EN=8'h02, bp_addr[1]=16'hC123. Run, then sync rise with cpu_addr=C123 -> stop, BP_HIT=8'h02. Write 8'h02 to off2 -> reads 8'h00.
- STEP_WAIT STEP_CNT=5, matching breakpoint on 4th rise -> stop there. Same match on 1st rise -> ignored.
- rst_n low during STEP_WAIT at count 2 -> state RUN, all registers 0, no nmi_req after release.
